// File: rtl/image_loader.sv
// Purpose : streams 8-bit pixels into a 784-entry frame RAM in raster order, then serves two registered read ports.
// Latency : a write lands on the edge of the transfer; reads return data one cycle after rd_en.
// Backpr. : s_ready is high only while loading and drops the cycle after the last pixel.
// Optional: define IMG_CHECKSUM_EN to build the 16-bit frame checksum; otherwise checksum is tied to 0.
// The consumer-done pulse is named release_pulse because "release" is a reserved word.
module image_loader #(
    parameter int N_PIX = 784,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          release_pulse,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          done,
    output logic [AW-1:0] wr_count,
    input  logic          rd_en,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    output logic [DW-1:0] data_out1,
    output logic [DW-1:0] data_out2,
    output logic [15:0]   checksum
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIX - 1);

    logic [1:0]    state;
    logic          xfer;
    logic [DW-1:0] mem [0:N_PIX-1];

    // Handshake flags are pure decodes of the state register, so they
    // change exactly one cycle after the transition that causes them.
    assign s_ready = (state == S_LOAD);
    assign done    = (state == S_FULL);
    assign xfer    = s_valid && s_ready;

    // Frame FSM and write pointer; the pointer parks at N_PIX while full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            wr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        wr_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        wr_count <= wr_count + 1'b1;
                        if (wr_count == LAST_ADDR) begin
                            state <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (release_pulse) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Single RAM write port; no reset so the array maps onto block RAM.
    // A transfer coinciding with reset is dropped along with the frame.
    always_ff @(posedge clk) begin
        if (rst && xfer) begin
            mem[wr_count] <= s_data;
        end
    end

    // Two registered read ports; same-cycle collision sees pre-write data,
    // out-of-range addresses read as zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out1 <= '0;
            data_out2 <= '0;
        end else if (rd_en) begin
            data_out1 <= (addr1 <= LAST_ADDR) ? mem[addr1] : '0;
            data_out2 <= (addr2 <= LAST_ADDR) ? mem[addr2] : '0;
        end
    end

`ifdef IMG_CHECKSUM_EN
    // Running unsigned byte sum of the current frame, cleared on frame start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum <= '0;
        end else if (state == S_IDLE && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + 16'(s_data);
        end
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: full loads, gapped loads, FULL-state pulses,
// mid-load reset, read/write collision and out-of-range reads.
// Inputs are driven 1 ns after the rising edge; outputs are checked there too.
module tb_image_loader;

`ifdef IMG_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        release_pulse;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        done;
    logic [9:0]  wr_count;
    logic        rd_en;
    logic [9:0]  addr1;
    logic [9:0]  addr2;
    logic [7:0]  data_out1;
    logic [7:0]  data_out2;
    logic [15:0] checksum;

    int checks   = 0;
    int failures = 0;

    image_loader dut (
        .clk(clk), .rst(rst), .start(start), .release_pulse(release_pulse),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .done(done),
        .wr_count(wr_count), .rd_en(rd_en), .addr1(addr1), .addr2(addr2),
        .data_out1(data_out1), .data_out2(data_out2), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0/1: i mod 256 (1 = s_valid toggles), mode 2: all 0xAA, mode 3: 3*i+1
    function automatic logic [7:0] pix(input int mode, input int idx);
        case (mode)
            2:       pix = 8'hAA;
            3:       pix = 8'((idx * 3 + 1) % 256);
            default: pix = 8'(idx % 256);
        endcase
    endfunction

    // Streams n pixels; returns cycles used and whether done rose early.
    task automatic stream(input int mode, input int n, output int cyc, output bit early);
        int idx;
        idx   = 0;
        cyc   = 0;
        early = 1'b0;
        while (idx < n && cyc < 4000) begin
            s_valid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            s_data  = pix(mode, idx);
            if (done) early = 1'b1;
            if (s_valid && s_ready) idx++;
            step();
            cyc++;
        end
        s_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a1, input logic [9:0] a2);
        rd_en = 1'b1;
        addr1 = a1;
        addr2 = a2;
        step();
        rd_en = 1'b0;
    endtask

    task automatic check_full_frame(input int mode, input int exp_cyc);
        int cyc;
        bit early;
        pulse_start();
        checks++;
        if (s_ready !== 1'b1) begin
            failures++; $display("FAIL load_ready mode%0d: got %b expected 1", mode, s_ready);
        end
        stream(mode, 784, cyc, early);
        checks++;
        if (cyc != exp_cyc) begin
            failures++; $display("FAIL load_cycles mode%0d: got %0d expected %0d", mode, cyc, exp_cyc);
        end
        checks++;
        if (early) begin
            failures++; $display("FAIL early_done mode%0d: got 1 expected 0", mode);
        end
        checks++;
        if (done !== 1'b1 || s_ready !== 1'b0 || wr_count !== 10'd784) begin
            failures++;
            $display("FAIL frame_end mode%0d: got done=%b rdy=%b cnt=%0d expected 1 0 784",
                     mode, done, s_ready, wr_count);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; release_pulse = 1'b0; s_valid = 1'b0;
        s_data = 8'h00; rd_en = 1'b0; addr1 = '0; addr2 = '0;
        step(); step();
        checks++;
        if (s_ready !== 1'b0 || done !== 1'b0 || wr_count !== 10'd0 ||
            data_out1 !== 8'h00 || data_out2 !== 8'h00 || checksum !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b done=%b cnt=%0d d1=%h d2=%h ck=%h expected all 0",
                     s_ready, done, wr_count, data_out1, data_out2, checksum);
        end
        rst = 1'b1;
        s_valid = 1'b1; s_data = 8'h33;
        step();
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0 || wr_count !== 10'd0) begin
            failures++;
            $display("FAIL idle_no_accept: got rdy=%b cnt=%0d expected 0 0", s_ready, wr_count);
        end
    endtask

    task automatic test_full_load;
        check_full_frame(0, 784);
        checks++;
        if (checksum !== (CK ? 16'h7EF8 : 16'h0000)) begin
            failures++;
            $display("FAIL checksum_t1: got %h expected %h", checksum, CK ? 16'h7EF8 : 16'h0000);
        end
        do_read(10'd5, 10'd783);
        checks++;
        if (data_out1 !== 8'h05 || data_out2 !== 8'h0F) begin
            failures++;
            $display("FAIL read_t1: got %h %h expected 05 0f", data_out1, data_out2);
        end
        addr1 = 10'd6; addr2 = 10'd7;
        step();
        checks++;
        if (data_out1 !== 8'h05 || data_out2 !== 8'h0F) begin
            failures++;
            $display("FAIL read_hold: got %h %h expected 05 0f", data_out1, data_out2);
        end
    endtask

    task automatic test_gapped_load;
        release_pulse = 1'b1;
        step();
        release_pulse = 1'b0;
        check_full_frame(1, 1567);
        do_read(10'd300, 10'd783);
        checks++;
        if (data_out1 !== 8'h2C || data_out2 !== 8'h0F) begin
            failures++;
            $display("FAIL read_t2: got %h %h expected 2c 0f", data_out1, data_out2);
        end
        s_valid = 1'b1; s_data = 8'h77;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready: got %b expected 0", s_ready);
        end
        step();
        s_valid = 1'b0;
        checks++;
        if (wr_count !== 10'd784 || done !== 1'b1) begin
            failures++;
            $display("FAIL full_no_write: got cnt=%0d done=%b expected 784 1", wr_count, done);
        end
        do_read(10'd0, 10'd783);
        checks++;
        if (data_out1 !== 8'h00 || data_out2 !== 8'h0F) begin
            failures++;
            $display("FAIL full_ram_intact: got %h %h expected 00 0f", data_out1, data_out2);
        end
    endtask

    task automatic test_full_pulses;
        pulse_start();
        checks++;
        if (done !== 1'b1 || s_ready !== 1'b0 || wr_count !== 10'd784) begin
            failures++;
            $display("FAIL full_start_ignored: got done=%b rdy=%b cnt=%0d expected 1 0 784",
                     done, s_ready, wr_count);
        end
        start = 1'b1; release_pulse = 1'b1;
        step();
        start = 1'b0; release_pulse = 1'b0;
        checks++;
        if (done !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL release_wins: got done=%b rdy=%b expected 0 0", done, s_ready);
        end
        step();
        checks++;
        if (s_ready !== 1'b0) begin
            failures++; $display("FAIL start_dropped: got rdy=%b expected 0", s_ready);
        end
        check_full_frame(2, 784);
        do_read(10'd0, 10'd400);
        checks++;
        if (data_out1 !== 8'hAA || data_out2 !== 8'hAA) begin
            failures++;
            $display("FAIL read_aa: got %h %h expected aa aa", data_out1, data_out2);
        end
        checks++;
        if (checksum !== (CK ? 16'h08A0 : 16'h0000)) begin
            failures++;
            $display("FAIL checksum_aa: got %h expected %h", checksum, CK ? 16'h08A0 : 16'h0000);
        end
    endtask

    task automatic test_mid_reset;
        int cyc;
        bit early;
        release_pulse = 1'b1;
        step();
        release_pulse = 1'b0;
        pulse_start();
        stream(3, 100, cyc, early);
        checks++;
        if (wr_count !== 10'd100) begin
            failures++; $display("FAIL partial_count: got %0d expected 100", wr_count);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (s_ready !== 1'b0 || done !== 1'b0 || wr_count !== 10'd0 ||
            data_out1 !== 8'h00 || data_out2 !== 8'h00 || checksum !== 16'h0000) begin
            failures++;
            $display("FAIL midload_reset: got rdy=%b done=%b cnt=%0d d1=%h d2=%h ck=%h expected all 0",
                     s_ready, done, wr_count, data_out1, data_out2, checksum);
        end
        do_read(10'd50, 10'd150);
        checks++;
        if (data_out1 !== 8'h97 || data_out2 !== 8'hAA) begin
            failures++;
            $display("FAIL ram_retained: got %h %h expected 97 aa", data_out1, data_out2);
        end
    endtask

    task automatic test_collision;
        int cyc;
        bit early;
        pulse_start();
        checks++;
        if (checksum !== 16'h0000 || wr_count !== 10'd0) begin
            failures++;
            $display("FAIL restart_clear: got ck=%h cnt=%0d expected 0 0", checksum, wr_count);
        end
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h10 + i);
            step();
        end
        s_valid = 1'b1; s_data = 8'h55;
        rd_en = 1'b1; addr1 = 10'd10; addr2 = 10'd900;
        step();
        s_valid = 1'b0; rd_en = 1'b0;
        checks++;
        if (data_out1 !== 8'h1F || data_out2 !== 8'h00) begin
            failures++;
            $display("FAIL collision_old: got %h %h expected 1f 00", data_out1, data_out2);
        end
        do_read(10'd10, 10'd9);
        checks++;
        if (data_out1 !== 8'h55 || data_out2 !== 8'h19) begin
            failures++;
            $display("FAIL collision_new: got %h %h expected 55 19", data_out1, data_out2);
        end
        checks++;
        if (wr_count !== 10'd11 || checksum !== (CK ? 16'h0122 : 16'h0000)) begin
            failures++;
            $display("FAIL partial_sum: got cnt=%0d ck=%h expected 11 %h",
                     wr_count, checksum, CK ? 16'h0122 : 16'h0000);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gapped_load();
        test_full_pulses();
        test_mid_reset();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
